// File: rtl/musa_ctrl_pkg.sv
// Shared encodings for the MUSA multicycle control unit: opcodes, ALU functions,
// branch selects, FSM states and the opcode-class bundle.
package musa_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_NOP   = 6'b000001;
  localparam logic [5:0] OP_HALT  = 6'b000010;
  localparam logic [5:0] OP_CALL  = 6'b000011;
  localparam logic [5:0] OP_RET   = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JR    = 6'b001110;
  localparam logic [5:0] OP_JPC   = 6'b001001;
  localparam logic [5:0] OP_BRFL  = 6'b010001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] BR_SEQ  = 2'b00;
  localparam logic [1:0] BR_LINK = 2'b01;
  localparam logic [1:0] BR_TGT  = 2'b10;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef struct packed {
    logic is_rtype;
    logic is_imm;
    logic is_load;
    logic is_store;
    logic is_jump;
    logic is_brfl;
    logic is_call;
    logic is_ret;
    logic is_halt;
    logic is_nop;
    logic is_legal;
  } opc_class_t;

endpackage

// File: rtl/musa_opcode_class.sv
// Combinational opcode classifier: one-hot instruction class plus a legality flag.
module musa_opcode_class
  import musa_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opc,
  output opc_class_t       cls
);

  always_comb begin
    cls = '0;
    case (opc)
      OPC_W'(OP_RTYPE): cls.is_rtype = 1'b1;
      OPC_W'(OP_ADDI), OPC_W'(OP_SUBI),
      OPC_W'(OP_ANDI), OPC_W'(OP_ORI): cls.is_imm = 1'b1;
      OPC_W'(OP_LW):   cls.is_load  = 1'b1;
      OPC_W'(OP_SW):   cls.is_store = 1'b1;
      OPC_W'(OP_JR), OPC_W'(OP_JPC): cls.is_jump = 1'b1;
      OPC_W'(OP_BRFL): cls.is_brfl  = 1'b1;
      OPC_W'(OP_CALL): cls.is_call  = 1'b1;
      OPC_W'(OP_RET):  cls.is_ret   = 1'b1;
      OPC_W'(OP_HALT): cls.is_halt  = 1'b1;
      OPC_W'(OP_NOP):  cls.is_nop   = 1'b1;
      default: ;
    endcase
    cls.is_legal = cls.is_rtype | cls.is_imm | cls.is_load | cls.is_store | cls.is_jump |
                   cls.is_brfl | cls.is_call | cls.is_ret | cls.is_halt | cls.is_nop;
  end

endmodule

// File: rtl/musa_multicycle_control.sv
// MUSA multicycle control FSM (IF/ID/EX/MEM/WB/HALT) with memory handshakes and
// optional wait timeout. Define MUSA_ILLEGAL_TRAP_EN to trap undefined opcodes into HALT.
module musa_multicycle_control
  import musa_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 32,
  parameter int OPC_W       = 6,
  parameter int FN_W        = 6,
  parameter int BR_W        = 2,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  output logic               imem_req,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  input  logic               flag_z,
  output logic               ir_load,
  output logic               pc_write,
  output logic               reg_read,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_imm,
  output logic [FN_W-1:0]    alu_fn,
  output logic [BR_W-1:0]    branch,
  output logic               push,
  output logic               pop,
  output logic               halted,
  output logic               illegal,
  output logic               bus_err,
  output logic [2:0]         state
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

`ifdef MUSA_ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = S_HALT;
`else
  localparam state_t ILL_NEXT = S_IF;
`endif

  state_t            state_q, state_d;
  logic [OPC_W-1:0]  ir_opc;
  logic [FN_W-1:0]   ir_fn;
  logic [CW-1:0]     wait_cnt;
  logic              waiting, timeout, bus_err_q;
  logic [FN_W-1:0]   fn_dec;
  opc_class_t        cls;
  logic              unused_instr;

  assign unused_instr = ^instr[INSTR_W-OPC_W-1:FN_W];

  musa_opcode_class #(.OPC_W(OPC_W)) u_class (
    .opc (ir_opc),
    .cls (cls)
  );

  // ALU function is held from EX through WB so the writeback sees a stable result select.
  always_comb begin
    fn_dec = '0;
    if (cls.is_rtype) fn_dec = ir_fn;
    else if (cls.is_load || cls.is_store) fn_dec = FN_W'(FN_ADD);
    else begin
      case (ir_opc)
        OPC_W'(OP_ADDI): fn_dec = FN_W'(FN_ADD);
        OPC_W'(OP_SUBI): fn_dec = FN_W'(FN_SUB);
        OPC_W'(OP_ANDI): fn_dec = FN_W'(FN_AND);
        OPC_W'(OP_ORI):  fn_dec = FN_W'(FN_OR);
        default: ;
      endcase
    end
  end

  assign waiting = !rst && ((state_q == S_IF && !imem_ack) || (state_q == S_MEM && !dmem_ack));
  assign timeout = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == TO_LAST);

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    reg_read    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    alu_fn      = '0;
    branch      = BR_W'(BR_SEQ);
    push        = 1'b0;
    pop         = 1'b0;
    halted      = 1'b0;
    // Strobes stay quiet for the whole time reset is held, even though state reads IF.
    if (!rst) begin
      case (state_q)
        S_IF: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = S_ID;
          end else if (timeout) state_d = S_HALT;
        end
        S_ID: begin
          reg_read = 1'b1;
          pc_write = 1'b1;
          if (cls.is_halt)       state_d = S_HALT;
          else if (!cls.is_legal) state_d = ILL_NEXT;
          else if (cls.is_nop)   state_d = S_IF;
          else                   state_d = S_EX;
        end
        S_EX: begin
          alu_fn      = fn_dec;
          alu_src_imm = cls.is_imm | cls.is_load | cls.is_store;
          if (cls.is_rtype || cls.is_imm)       state_d = S_WB;
          else if (cls.is_load || cls.is_store) state_d = S_MEM;
          else begin
            state_d = S_IF;
            if (cls.is_jump) begin
              branch = BR_W'(BR_TGT); pc_write = 1'b1;
            end else if (cls.is_brfl) begin
              branch = BR_W'(BR_TGT); pc_write = flag_z;
            end else if (cls.is_call) begin
              branch = BR_W'(BR_LINK); pc_write = 1'b1; push = 1'b1;
            end else if (cls.is_ret) begin
              branch = BR_W'(BR_LINK); pc_write = 1'b1; pop = 1'b1;
            end
          end
        end
        S_MEM: begin
          alu_fn   = fn_dec;
          dmem_req = 1'b1;
          dmem_we  = cls.is_store;
          if (dmem_ack)     state_d = cls.is_load ? S_WB : S_IF;
          else if (timeout) state_d = S_HALT;
        end
        S_WB: begin
          alu_fn     = fn_dec;
          reg_write  = 1'b1;
          mem_to_reg = cls.is_load;
          state_d    = S_IF;
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_IF;
      endcase
    end
  end

`ifdef MUSA_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else if (state_q == S_ID && !cls.is_legal) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      ir_opc    <= '0;
      ir_fn     <= '0;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (MEM_TIMEOUT > 0 && waiting && !timeout) ? wait_cnt + CW'(1) : '0;
      if (ir_load) begin
        ir_opc <= instr[INSTR_W-1 -: OPC_W];
        ir_fn  <= instr[FN_W-1:0];
      end
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_musa_multicycle_control.sv
// Self-checking bench: per-instruction strobe/cycle summaries checked against an
// instruction-level reference model, plus directed reset, halt, illegal and timeout cases.
module tb_musa_multicycle_control;

  localparam logic [5:0] RT = 6'b000000, NOP = 6'b000001, HLT = 6'b000010, CALL = 6'b000011,
    RET = 6'b000111, ADDI = 6'b001000, SUBI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101,
    JR = 6'b001110, JPC = 6'b001001, BRFL = 6'b010001, LW = 6'b100011, SW = 6'b101011;

  typedef struct packed {
    logic [7:0] cyc, rw_at, ireq, dreq, dwe, rr, pcw, rw, m2r, imm, b10, b01, push, pop, both, err;
    logic [5:0] fn;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr = '0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0, flag_z = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_load, pc_write, reg_read, reg_write, mem_to_reg;
  logic alu_src_imm, push, pop, halted, illegal, bus_err;
  logic [5:0] alu_fn;
  logic [1:0] branch;
  logic [2:0] state;
  logic [21:0] all_out;

  logic t_rst = 1'b1, t_imem_ack = 1'b0, t_dmem_ack = 1'b0;
  logic t_imem_req, t_dmem_req, t_dmem_we, t_ir_load, t_pc_write, t_reg_read, t_reg_write;
  logic t_mem_to_reg, t_alu_src_imm, t_push, t_pop, t_halted, t_illegal, t_bus_err;
  logic [5:0] t_alu_fn;
  logic [1:0] t_branch;
  logic [2:0] t_state;

  int n_chk = 0, n_fail = 0;
  logic [5:0] ops [0:12] = '{RT, NOP, CALL, RET, ADDI, SUBI, ANDI, ORI, JR, JPC, BRFL, LW, SW};

  always #5 clk = ~clk;

  assign all_out = {imem_req, dmem_req, dmem_we, ir_load, pc_write, reg_read, reg_write,
                    mem_to_reg, alu_src_imm, alu_fn, branch, push, pop, halted, illegal, bus_err};

  musa_multicycle_control u_dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .flag_z(flag_z),
    .ir_load(ir_load), .pc_write(pc_write), .reg_read(reg_read), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_imm(alu_src_imm), .alu_fn(alu_fn), .branch(branch),
    .push(push), .pop(pop), .halted(halted), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  musa_multicycle_control #(.MEM_TIMEOUT(5)) u_dut_to (
    .clk(clk), .rst(t_rst), .instr(instr), .imem_req(t_imem_req), .imem_ack(t_imem_ack),
    .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .dmem_ack(t_dmem_ack), .flag_z(flag_z),
    .ir_load(t_ir_load), .pc_write(t_pc_write), .reg_read(t_reg_read), .reg_write(t_reg_write),
    .mem_to_reg(t_mem_to_reg), .alu_src_imm(t_alu_src_imm), .alu_fn(t_alu_fn), .branch(t_branch),
    .push(t_push), .pop(t_pop), .halted(t_halted), .illegal(t_illegal), .bus_err(t_bus_err),
    .state(t_state)
  );

  // Instruction-level expectations: total cycles and how many cycles each strobe is seen.
  function automatic obs_t model(input logic [5:0] opc, input logic [5:0] fn, input logic fz,
                                 input int idl, input int mdl);
    obs_t e;
    e = '0;
    e.ireq = 8'(idl + 1); e.rr = 8'd1; e.pcw = 8'd1; e.cyc = 8'(idl + 2);
    case (opc)
      RT, ADDI, SUBI, ANDI, ORI: begin
        e.cyc = 8'(idl + 4); e.rw = 8'd1; e.imm = (opc == RT) ? 8'd0 : 8'd1;
        e.fn = (opc == RT) ? fn : (opc == ADDI) ? 6'b100000 : (opc == SUBI) ? 6'b100010 :
               (opc == ANDI) ? 6'b100100 : 6'b100101;
      end
      LW: begin
        e.cyc = 8'(idl + mdl + 5); e.rw = 8'd1; e.fn = 6'b100000; e.m2r = 8'd1; e.imm = 8'd1;
        e.dreq = 8'(mdl + 1);
      end
      SW: begin
        e.cyc = 8'(idl + mdl + 4); e.imm = 8'd1; e.dreq = 8'(mdl + 1); e.dwe = 8'(mdl + 1);
      end
      JR, JPC: begin e.cyc = 8'(idl + 3); e.pcw = 8'd2; e.b10 = 8'd1; end
      BRFL:    begin e.cyc = 8'(idl + 3); e.pcw = fz ? 8'd2 : 8'd1; e.b10 = 8'd1; end
      CALL:    begin e.cyc = 8'(idl + 3); e.pcw = 8'd2; e.b01 = 8'd1; e.push = 8'd1; end
      RET:     begin e.cyc = 8'(idl + 3); e.pcw = 8'd2; e.b01 = 8'd1; e.pop = 8'd1; end
      default: ;
    endcase
    if (e.rw != 0) e.rw_at = e.cyc;
    return e;
  endfunction

  // Runs one instruction from IF until the next fetch (or halt), with spurious acks
  // thrown in whenever the matching request is idle.
  task automatic exec(input logic [5:0] opc, input logic [5:0] fn, input logic fz,
                      input int idl, input int mdl, output obs_t o);
    int wi, wd;
    logic seen;
    o = '0; wi = 0; wd = 0; seen = 1'b0;
    instr = {opc, 20'($urandom), fn};
    flag_z = fz;
    for (int c = 1; c <= 64; c++) begin
      imem_ack = imem_req ? (wi == idl) : 1'($urandom);
      dmem_ack = dmem_req ? (wd == mdl) : 1'($urandom);
      #1;
      if (imem_req)    o.ireq += 8'd1;
      if (dmem_req)    o.dreq += 8'd1;
      if (dmem_we)     o.dwe  += 8'd1;
      if (reg_read)    o.rr   += 8'd1;
      if (pc_write)    o.pcw  += 8'd1;
      if (alu_src_imm) o.imm  += 8'd1;
      if (branch == 2'b10) o.b10 += 8'd1;
      if (branch == 2'b01) o.b01 += 8'd1;
      if (push)        o.push += 8'd1;
      if (pop)         o.pop  += 8'd1;
      if (push && pop) o.both += 8'd1;
      if (bus_err || illegal) o.err += 8'd1;
      if (reg_write) begin
        o.rw += 8'd1; o.fn = alu_fn; o.rw_at = 8'(c);
        if (mem_to_reg) o.m2r += 8'd1;
      end
      if (imem_req) wi++;
      if (dmem_req) wd++;
      if (ir_load) seen = 1'b1;
      @(posedge clk); #1;
      o.cyc = 8'(c);
      if (seen && (imem_req || halted)) break;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (state !== 3'd0 || all_out !== '0) begin
      n_fail++; $display("FAIL reset_init: state=%0d outs=%h want state=0 outs=0", state, all_out);
    end
    rst = 1'b0;
    instr = {LW, 20'h12345, 6'd0}; flag_z = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_mem_wait: dmem_req=%b want 1", dmem_req);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (state !== 3'd0 || all_out !== '0) begin
        n_fail++; $display("FAIL reset_mid_mem[%0d]: state=%0d outs=%h want 0/0", i, state, all_out);
      end
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: imem_req=%b dmem_req=%b want 1/0", imem_req, dmem_req);
    end
  endtask

  task automatic test_add();
    obs_t o, e;
    exec(RT, 6'b100000, 1'b0, 0, 0, o);
    e = model(RT, 6'b100000, 1'b0, 0, 0);
    n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL add: got %p want %p", o, e); end
    n_chk++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL add_next_fetch: imem_req=%b want 1", imem_req); end
  endtask

  task automatic test_lw_wait();
    obs_t o, e;
    exec(LW, 6'd0, 1'b0, 0, 3, o);
    e = model(LW, 6'd0, 1'b0, 0, 3);
    n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL lw_wait: got %p want %p", o, e); end
  endtask

  task automatic test_brfl();
    obs_t o, e;
    for (int f = 0; f < 2; f++) begin
      exec(BRFL, 6'd0, 1'(f), 0, 0, o);
      e = model(BRFL, 6'd0, 1'(f), 0, 0);
      n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL brfl_z%0d: got %p want %p", f, o, e); end
    end
  endtask

  task automatic test_call_ret();
    obs_t o, e;
    exec(CALL, 6'd0, 1'b0, 0, 0, o);
    e = model(CALL, 6'd0, 1'b0, 0, 0);
    n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL call: got %p want %p", o, e); end
    exec(RET, 6'd0, 1'b0, 1, 0, o);
    e = model(RET, 6'd0, 1'b0, 1, 0);
    n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL ret: got %p want %p", o, e); end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [5:0] opc, fn;
    logic fz;
    int idl, mdl;
    for (int i = 0; i < 40; i++) begin
      opc = ops[$urandom_range(0, 12)];
      fn  = 6'($urandom);
      fz  = 1'($urandom);
      idl = $urandom_range(0, 3);
      mdl = $urandom_range(0, 3);
      exec(opc, fn, fz, idl, mdl, o);
      e = model(opc, fn, fz, idl, mdl);
      n_chk++;
      if (o !== e) begin
        n_fail++; $display("FAIL random[%0d] opc=%b: got %p want %p", i, opc, o, e);
      end
    end
    exec(SW, 6'd0, 1'b0, 30, 20, o);
    e = model(SW, 6'd0, 1'b0, 30, 20);
    n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL long_wait_no_timeout: got %p want %p", o, e); end
  endtask

  task automatic test_illegal();
    obs_t o, e;
    exec(6'b111111, 6'd0, 1'b0, 1, 0, o);
    e = model(6'b111111, 6'd0, 1'b0, 1, 0);
    n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL illegal_seq: got %p want %p", o, e); end
    n_chk++;
`ifdef MUSA_ILLEGAL_TRAP_EN
    if (illegal !== 1'b1 || halted !== 1'b1) begin
      n_fail++; $display("FAIL illegal_trap: illegal=%b halted=%b want 1/1", illegal, halted);
    end
    do_reset();
`else
    if (illegal !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL illegal_as_nop: illegal=%b halted=%b imem_req=%b want 0/0/1",
                         illegal, halted, imem_req);
    end
`endif
  endtask

  task automatic test_halt();
    obs_t o, e;
    int bad;
    exec(HLT, 6'd0, 1'b0, 0, 0, o);
    e = model(HLT, 6'd0, 1'b0, 0, 0);
    n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL halt_entry: got %p want %p", o, e); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      #1;
      if (imem_req || dmem_req || !halted || state !== 3'd5) bad++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL halt_sticky: bad cycles=%0d want 0", bad); end
    do_reset();
  endtask

  task automatic test_timeout();
    int bad;
    t_rst = 1'b1; t_imem_ack = 1'b0; t_dmem_ack = 1'b0;
    @(posedge clk); #1;
    t_rst = 1'b0;
    bad = 0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (t_imem_req !== 1'b1 || t_bus_err !== 1'b0 || t_halted !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL timeout_wait: bad cycles=%0d want 0", bad); end
    n_chk++;
    if (t_bus_err !== 1'b1 || t_halted !== 1'b1 || t_imem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fire: bus_err=%b halted=%b imem_req=%b want 1/1/0",
                         t_bus_err, t_halted, t_imem_req);
    end
    @(posedge clk); #1;
    n_chk++;
    if (t_bus_err !== 1'b1 || t_state !== 3'd5) begin
      n_fail++; $display("FAIL timeout_sticky: bus_err=%b state=%0d want 1/5", t_bus_err, t_state);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_brfl();
    test_call_ret();
    test_random();
    test_illegal();
    test_halt();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
